// File: rtl/bcd_display_scanner.sv
// Sequential binary-to-BCD converter (double dabble) driving a multiplexed
// seven-segment display with leading-zero blanking, minus sign and overflow.
module bcd_display_scanner #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned CLK_DIV       = 100000,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              signed_mode,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              busy,
  output logic              valid,
  output logic              overflow
);

  localparam int unsigned NB = (WIDTH + 2) / 3 + 1;
  localparam int unsigned BW = NB * 4;
  localparam int unsigned EN = (NB > DIGITS) ? NB : DIGITS;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = $clog2(DIGITS);

  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                    state, state_n;
  logic [WIDTH-1:0]          mag, mag_n;
  logic [BW-1:0]             bcd, bcd_n, adj;
  logic [CW-1:0]             cnt, cnt_n;
  logic                      neg, neg_n;
  logic [DIGITS-1:0][6:0]    disp, disp_n, commit_disp;
  logic                      valid_n, overflow_n, busy_n, commit_ovf;
  logic [PW-1:0]             pre, pre_n;
  logic [IW-1:0]             idx, idx_n;
  logic [DIGITS-1:0]         an_n;
  logic [6:0]                seg_n;
  logic [EN*4-1:0]           ext;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: add 3 to every nibble >= 5 before the shift
  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < NB; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Segment patterns and overflow for the finished BCD result
  always_comb begin
    int unsigned msd;
    int unsigned p;
    logic        hi_nz;
    ext   = (EN*4)'(bcd);
    msd   = 0;
    hi_nz = 1'b0;
    for (int unsigned i = 0; i < EN; i++) begin
      if (ext[i*4 +: 4] != 4'd0) begin
        msd = i;
        if (i >= DIGITS) hi_nz = 1'b1;
      end
    end
    p          = msd + 1 + (neg ? 1 : 0);
    commit_ovf = hi_nz | (neg & (p > DIGITS));
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (commit_ovf) begin
        commit_disp[i] = SEG_MINUS;
      end else if (BLANK_LEADING != 0) begin
        if (i <= msd)                  commit_disp[i] = seg_code(ext[i*4 +: 4]);
        else if (neg && i == msd + 1)  commit_disp[i] = SEG_MINUS;
        else                           commit_disp[i] = SEG_BLANK;
      end else begin
        if (neg && i == DIGITS - 1)    commit_disp[i] = SEG_MINUS;
        else                           commit_disp[i] = seg_code(ext[i*4 +: 4]);
      end
    end
  end

  // Next-state, datapath and scan logic
  always_comb begin
    state_n    = state;
    mag_n      = mag;
    bcd_n      = bcd;
    cnt_n      = cnt;
    neg_n      = neg;
    disp_n     = disp;
    valid_n    = valid;
    overflow_n = overflow;
    busy_n     = busy;
    pre_n      = pre + PW'(1);
    idx_n      = idx;

    if (pre == PW'(CLK_DIV - 1)) begin
      pre_n = '0;
      idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end

    case (state)
      IDLE: begin
        neg_n   = signed_mode & value[WIDTH-1];
        mag_n   = neg_n ? WIDTH'(~value + WIDTH'(1)) : value;
        bcd_n   = '0;
        cnt_n   = '0;
        busy_n  = 1'b1;
        state_n = SHIFT;
      end
      SHIFT: begin
        bcd_n = {adj[BW-2:0], mag[WIDTH-1]};
        mag_n = {mag[WIDTH-2:0], 1'b0};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state_n = COMMIT;
      end
      COMMIT: begin
        disp_n     = commit_disp;
        overflow_n = commit_ovf;
        valid_n    = 1'b1;
        busy_n     = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase

    an_n  = valid_n ? ~(DIGITS'(1) << idx_n) : '1;
    seg_n = valid_n ? disp_n[idx_n] : SEG_BLANK;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      disp     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      pre      <= '0;
      idx      <= '0;
      an       <= '1;
      seg      <= SEG_BLANK;
    end else begin
      state    <= state_n;
      mag      <= mag_n;
      bcd      <= bcd_n;
      cnt      <= cnt_n;
      neg      <= neg_n;
      disp     <= disp_n;
      valid    <= valid_n;
      overflow <= overflow_n;
      busy     <= busy_n;
      pre      <= pre_n;
      idx      <= idx_n;
      an       <= an_n;
      seg      <= seg_n;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised self-checking bench for bcd_display_scanner (blanked and zero-padded builds).
module tb_bcd_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        signed_mode;
  logic [3:0]  an1, an0;
  logic [6:0]  seg1, seg0;
  logic        busy1, busy0, valid1, valid0, ovf1, ovf0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(.WIDTH(16), .DIGITS(4), .CLK_DIV(4), .BLANK_LEADING(1)) dut1 (
    .clk(clk), .reset(reset), .value(value), .signed_mode(signed_mode),
    .an(an1), .seg(seg1), .busy(busy1), .valid(valid1), .overflow(ovf1));

  bcd_display_scanner #(.WIDTH(16), .DIGITS(4), .CLK_DIV(4), .BLANK_LEADING(0)) dut0 (
    .clk(clk), .reset(reset), .value(value), .signed_mode(signed_mode),
    .an(an0), .seg(seg0), .busy(busy0), .valid(valid0), .overflow(ovf0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] digit_code(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic int an_index(input logic [3:0] a);
    case (a)
      4'hE: return 0;
      4'hD: return 1;
      4'hB: return 2;
      4'h7: return 3;
      default: return -1;
    endcase
  endfunction

  // Reference: decimal digits by division, then place them on the 4 positions
  task automatic model(input logic [15:0] v, input bit s, input bit bl,
                       output logic [27:0] segs, output bit ovf);
    bit neg;
    int m, nd;
    int d [5];
    neg = s && v[15];
    m = neg ? 65536 - int'(v) : int'(v);
    for (int i = 0; i < 5; i++) begin
      d[i] = m % 10;
      m = m / 10;
    end
    nd = 1;
    for (int i = 0; i < 5; i++) if (d[i] != 0) nd = i + 1;
    ovf = (nd > 4) || (neg && nd + 1 > 4);
    for (int i = 0; i < 4; i++) begin
      logic [6:0] c;
      if (ovf)                 c = 7'h3F;
      else if (bl) begin
        if (i < nd)            c = digit_code(d[i]);
        else if (neg && i == nd) c = 7'h3F;
        else                   c = 7'h7F;
      end else begin
        if (neg && i == 3)     c = 7'h3F;
        else                   c = digit_code(d[i]);
      end
      segs[i*7 +: 7] = c;
    end
  endtask

  task automatic wait_busy(input logic lvl);
    int n = 0;
    @(negedge clk);
    while (busy1 !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("busy_timeout", 32'(busy1), 32'(lvl));
  endtask

  // Present a value and wait until a commit holding it has happened
  task automatic apply(input logic [15:0] v, input bit s);
    @(negedge clk);
    value = v;
    signed_mode = s;
    if (busy1 !== 1'b0) wait_busy(1'b0);
    wait_busy(1'b1);
    wait_busy(1'b0);
  endtask

  // Record the pattern shown at each position over a few scan rounds
  task automatic capture(output logic [27:0] s1, output logic [27:0] s0);
    int bad = 0;
    s1 = '1;
    s0 = '1;
    for (int k = 0; k < 24; k++) begin
      int i1, i0;
      @(negedge clk);
      i1 = an_index(an1);
      i0 = an_index(an0);
      if (i1 < 0 || i0 != i1) bad++;
      else begin
        s1[i1*7 +: 7] = seg1;
        s0[i0*7 +: 7] = seg0;
      end
    end
    check("an_onehot", 32'(bad), 32'd0);
  endtask

  task automatic run_case(input string tag, input logic [15:0] v, input bit s);
    logic [27:0] e1, e0, g1, g0;
    bit o1, o0;
    apply(v, s);
    capture(g1, g0);
    model(v, s, 1'b1, e1, o1);
    model(v, s, 1'b0, e0, o0);
    check({tag, "_seg_bl1"}, 32'(g1), 32'(e1));
    check({tag, "_ovf_bl1"}, 32'(ovf1), 32'(o1));
    check({tag, "_seg_bl0"}, 32'(g0), 32'(e0));
    check({tag, "_ovf_bl0"}, 32'(ovf0), 32'(o0));
  endtask

  // From reset release: first commit after 17 edges, busy for 17 cycles
  task automatic timing_after_release;
    int first_valid = -1;
    int busy_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk);
      #1;
      if (valid1 && first_valid < 0) first_valid = k;
      if (busy1) busy_cnt++;
    end
    check("first_valid_edge", 32'(first_valid), 32'd17);
    check("busy_cycles", 32'(busy_cnt), 32'd17);
  endtask

  initial begin
    logic [27:0] e1, e0, g1, g0, eo;
    bit o1;
    int scan_err, k0, start, bad, gap, phase;
    logic [3:0] seq [40];

    reset = 1'b1;
    value = 16'd1234;
    signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an1), 32'hF);
    check("rst_seg", 32'(seg1), 32'h7F);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_ovf", 32'(ovf1), 32'd0);

    timing_after_release();

    // Scan order E,D,B,7 with 4 clocks per position
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seq[k] = an1;
    end
    k0 = 1;
    while (k0 < 39 && seq[k0] == seq[0]) k0++;
    start = an_index(seq[k0]);
    scan_err = (start < 0) ? 1 : 0;
    for (int j = 0; j < 16 && start >= 0; j++) begin
      logic [3:0] ea;
      ea = ~(4'b0001 << ((start + j / 4) % 4));
      if (seq[k0 + j] !== ea) scan_err++;
    end
    check("scan_order", 32'(scan_err), 32'd0);
    capture(g1, g0);
    model(16'd1234, 1'b0, 1'b1, e1, o1);
    check("t1_seg", 32'(g1), 32'(e1));
    check("t1_ovf", 32'(ovf1), 32'(o1));

    // Directed boundary cases
    run_case("u7", 16'd7, 1'b0);
    run_case("u0", 16'd0, 1'b0);
    run_case("s_m123", 16'hFF85, 1'b1);
    run_case("u10000", 16'd10000, 1'b0);
    run_case("s_m1000", 16'hFC18, 1'b1);
    run_case("s_min", 16'h8000, 1'b1);
    run_case("s_m999", 16'hFC19, 1'b1);
    run_case("u9999", 16'd9999, 1'b0);
    run_case("u65535", 16'hFFFF, 1'b0);
    run_case("s_m1", 16'hFFFF, 1'b1);

    // Randomised cases, biased towards small magnitudes
    for (int r = 0; r < 25; r++) begin
      logic [15:0] v;
      bit s;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: v = 16'($urandom_range(0, 99));
        1: v = s ? 16'(-$urandom_range(0, 1200)) : 16'($urandom_range(0, 12000));
        default: v = 16'($urandom);
      endcase
      run_case("rand", v, s);
    end

    // Value change mid-conversion is not seen until the next sample
    @(negedge clk);
    value = 16'd1234;
    signed_mode = 1'b0;
    if (busy1 !== 1'b0) wait_busy(1'b0);
    wait_busy(1'b1);
    repeat (2) @(negedge clk);
    value = 16'd42;
    wait_busy(1'b0);
    model(16'd1234, 1'b0, 1'b1, eo, o1);
    model(16'd42, 1'b0, 1'b1, e1, o1);
    bad = 0;
    gap = 0;
    phase = 0;
    for (int k = 0; k < 100 && phase < 2; k++) begin
      int i1;
      @(negedge clk);
      gap++;
      i1 = an_index(an1);
      if (i1 < 0 || (seg1 !== eo[i1*7 +: 7] && seg1 !== e1[i1*7 +: 7])) bad++;
      if (phase == 0 && busy1) phase = 1;
      else if (phase == 1 && !busy1) phase = 2;
    end
    check("commit_gap", 32'(gap), 32'd18);
    check("no_partial", 32'(bad), 32'd0);
    capture(g1, g0);
    check("t5_seg42", 32'(g1), 32'(e1));

    // Reset in the middle of a conversion
    wait_busy(1'b0);
    wait_busy(1'b1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_an", 32'(an1), 32'hF);
    check("mid_rst_seg", 32'(seg1), 32'h7F);
    check("mid_rst_busy", 32'(busy1), 32'd0);
    check("mid_rst_valid", 32'(valid1), 32'd0);
    @(posedge clk);
    timing_after_release();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
